// File: rtl/led_loss_stretcher_mc_pkg.sv
// Shared definitions for the multi-channel signal-loss LED stretcher.
// Holds the default timing parameters, the per-channel state encoding and
// a helper that sizes the counters used for the prescaler, the blink divider
// and the hold timer.
package led_loss_stretcher_mc_pkg;

  // Defaults for a 54 MHz front-panel clock
  localparam int DEF_N_CH     = 4;
  localparam int DEF_CLK_KHZ  = 54000;
  localparam int DEF_OFF_MS   = 100;
  localparam int DEF_BLINK_MS = 250;
  localparam int DEF_CNT_W    = 8;

  // Channel states; the unused code 2'd3 is steered back to S_OFF
  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_ON   = 2'd1,
    S_HOLD = 2'd2
  } chan_state_e;

  // Bits needed for a counter running 0..modulus-1, never less than one
  function automatic int cntWidth(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/led_loss_stretcher_mc_chan.sv
// One channel of the loss stretcher.
// Runs the OFF/ON/HOLD state machine, times the minimum LED-off hold in
// millisecond ticks and keeps a saturating count of loss events.
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous reset, active low
//   sigS_i      synchronized lock/valid for this channel
//   blinkEn_i   1 = blink the LED while the signal is present
//   phase_i     shared blink phase
//   tick_i      1 ms pulse
//   cntClr_i    synchronous clear of the loss counter
//   led_o       registered LED drive, 1 = lit
//   lossCnt_o   saturating loss-event counter
module led_loss_stretcher_mc_chan
  import led_loss_stretcher_mc_pkg::*;
#(
  parameter int OFF_MS = DEF_OFF_MS,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sigS_i,
  input  logic             blinkEn_i,
  input  logic             phase_i,
  input  logic             tick_i,
  input  logic             cntClr_i,
  output logic             led_o,
  output logic [CNT_W-1:0] lossCnt_o
);

  localparam int TW = $clog2(OFF_MS + 1);
  localparam logic [TW-1:0]    HOLD_LAST = TW'(OFF_MS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  chan_state_e      state_q, state_d;
  logic [TW-1:0]    holdCnt_q, holdCnt_d;
  logic [CNT_W-1:0] lossCnt_q, lossCnt_d;
  logic             led_q, led_d;
  logic             lossEvent;

  // The hold timer only advances on ticks seen while already in S_HOLD, so a
  // tick landing in the entry cycle is not counted; the hold therefore lasts
  // between (OFF_MS-1) and OFF_MS full milliseconds. sigS_i is looked at
  // again only on the final tick. A loss event wins over a coincident clear.
  always_comb begin
    state_d   = state_q;
    holdCnt_d = holdCnt_q;
    lossCnt_d = cntClr_i ? '0 : lossCnt_q;
    led_d     = 1'b0;
    lossEvent = 1'b0;

    case (state_q)
      S_OFF: begin
        if (sigS_i) state_d = S_ON;
      end
      S_ON: begin
        led_d = blinkEn_i ? phase_i : 1'b1;
        if (!sigS_i) begin
          state_d   = S_HOLD;
          holdCnt_d = '0;
          lossEvent = 1'b1;
        end
      end
      S_HOLD: begin
        if (tick_i) begin
          if (holdCnt_q == HOLD_LAST) begin
            state_d = sigS_i ? S_ON : S_OFF;
          end else begin
            holdCnt_d = holdCnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_OFF;
      end
    endcase

    if (lossEvent) begin
      if (cntClr_i) begin
        lossCnt_d = CNT_ONE;
      end else if (lossCnt_q != CNT_MAX) begin
        lossCnt_d = lossCnt_q + 1'b1;
      end
    end
  end

  // State, timer, counter and the registered LED drive
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_OFF;
      holdCnt_q <= '0;
      lossCnt_q <= '0;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      holdCnt_q <= holdCnt_d;
      lossCnt_q <= lossCnt_d;
      led_q     <= led_d;
    end
  end

  assign led_o     = led_q;
  assign lossCnt_o = lossCnt_q;

endmodule

// File: rtl/led_loss_stretcher_mc.sv
// Multi-channel signal-loss indicator for the tuner front panel.
// Synchronizes the per-channel lock inputs, derives a 1 ms tick and a shared
// blink phase, and runs one stretcher channel per LED so that even a single
// cycle dropout blanks the LED for a visible time.
// Ports:
//   CLK        system clock
//   RST        asynchronous reset, active low
//   SIGNAL_IN  per-channel lock/valid, asynchronous to CLK
//   BLINK_EN   per-channel blink enable while the signal is present
//   CNT_CLR    synchronous clear of all loss counters
//   LED        registered LED drives, 1 = lit
//   LOSS_CNT   loss counters, channel k at [k*CNT_W +: CNT_W]
module led_loss_stretcher_mc
  import led_loss_stretcher_mc_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int CLK_KHZ  = DEF_CLK_KHZ,
  parameter int OFF_MS   = DEF_OFF_MS,
  parameter int BLINK_MS = DEF_BLINK_MS,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_CH-1:0]       SIGNAL_IN,
  input  logic [N_CH-1:0]       BLINK_EN,
  input  logic                  CNT_CLR,
  output logic [N_CH-1:0]       LED,
  output logic [N_CH*CNT_W-1:0] LOSS_CNT
);

  localparam int PW = cntWidth(CLK_KHZ);
  localparam int BW = cntWidth(BLINK_MS);
  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_KHZ - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

  logic [N_CH-1:0] syncStage1_q;
  logic [N_CH-1:0] sigSync_q;
  logic [PW-1:0]   preCnt_q, preCnt_d;
  logic [BW-1:0]   blinkCnt_q, blinkCnt_d;
  logic            phase_q, phase_d;
  logic            tick;

  // Two-flop synchronizer per channel
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      syncStage1_q <= '0;
      sigSync_q    <= '0;
    end else begin
      syncStage1_q <= SIGNAL_IN;
      sigSync_q    <= syncStage1_q;
    end
  end

  // Free-running millisecond prescaler and the blink divider it feeds;
  // the phase flips on every BLINK_MS-th tick
  assign tick = (preCnt_q == PRE_LAST);

  always_comb begin
    preCnt_d   = tick ? '0 : preCnt_q + 1'b1;
    blinkCnt_d = blinkCnt_q;
    phase_d    = phase_q;
    if (tick) begin
      if (blinkCnt_q == BLINK_LAST) begin
        blinkCnt_d = '0;
        phase_d    = ~phase_q;
      end else begin
        blinkCnt_d = blinkCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      preCnt_q   <= '0;
      blinkCnt_q <= '0;
      phase_q    <= 1'b0;
    end else begin
      preCnt_q   <= preCnt_d;
      blinkCnt_q <= blinkCnt_d;
      phase_q    <= phase_d;
    end
  end

  // One stretcher per channel
  for (genvar k = 0; k < N_CH; k++) begin : gChan
    led_loss_stretcher_mc_chan #(
      .OFF_MS (OFF_MS),
      .CNT_W  (CNT_W)
    ) uChan (
      .clk_i     (CLK),
      .rst_ni    (RST),
      .sigS_i    (sigSync_q[k]),
      .blinkEn_i (BLINK_EN[k]),
      .phase_i   (phase_q),
      .tick_i    (tick),
      .cntClr_i  (CNT_CLR),
      .led_o     (LED[k]),
      .lossCnt_o (LOSS_CNT[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_led_loss_stretcher_mc.sv
// Directed bench for the loss stretcher with a 10-cycle millisecond,
// a 3 ms hold, a 2 ms blink half-period and 2-bit loss counters.
module tb_led_loss_stretcher_mc;

  localparam int N_CH     = 4;
  localparam int CLK_KHZ  = 10;
  localparam int OFF_MS   = 3;
  localparam int BLINK_MS = 2;
  localparam int CNT_W    = 2;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic [N_CH-1:0]       SIGNAL_IN;
  logic [N_CH-1:0]       BLINK_EN;
  logic                  CNT_CLR;
  logic [N_CH-1:0]       LED;
  logic [N_CH*CNT_W-1:0] LOSS_CNT;

  int passCnt  = 0;
  int totalCnt = 0;

  led_loss_stretcher_mc #(
    .N_CH     (N_CH),
    .CLK_KHZ  (CLK_KHZ),
    .OFF_MS   (OFF_MS),
    .BLINK_MS (BLINK_MS),
    .CNT_W    (CNT_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SIGNAL_IN (SIGNAL_IN),
    .BLINK_EN  (BLINK_EN),
    .CNT_CLR   (CNT_CLR),
    .LED       (LED),
    .LOSS_CNT  (LOSS_CNT)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge
  always #5 CLK = ~CLK;

  // One comparison: counts it, and on a miss reports tag, observed, expected
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // A one-clock dropout on a channel
  task automatic applyStimulus(input logic [1:0] ch);
    SIGNAL_IN[ch] = 1'b0;
    @(negedge CLK);
    SIGNAL_IN[ch] = 1'b1;
  endtask

  // Walks falling edges until LED[ch] shows val, giving up after maxCyc
  task automatic waitLed(input logic [1:0] ch, input logic val, input int maxCyc,
                         output int cycles, output logic ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < maxCyc) begin
      if (LED[ch] === val) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
      cycles++;
    end
  endtask

  // Walks falling edges until LED[ch] changes from its present value
  task automatic waitToggle(input logic [1:0] ch, input int maxCyc,
                            output int cycles, output logic ok);
    logic prev;
    prev   = LED[ch];
    cycles = 0;
    ok     = 1'b0;
    while (cycles < maxCyc) begin
      @(negedge CLK);
      cycles++;
      if (LED[ch] !== prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // The whole directed sequence
  initial begin
    int   cyc;
    int   lowLen;
    logic ok;
    logic [1:0] expCnt [5];
    expCnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    RST       = 1'b0;
    SIGNAL_IN = '0;
    BLINK_EN  = '0;
    CNT_CLR   = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    checkOutput("reset_led", 32'(LED), 32'd0);
    checkOutput("reset_cnt", 32'(LOSS_CNT), 32'd0);
    RST = 1'b1;
    repeat (3) @(negedge CLK);

    // Channel 0 rise: LED follows exactly four clocks later
    $display("[TB] step 1: rise latency");
    SIGNAL_IN[0] = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("rise_led0_at3", 32'(LED[0]), 32'd0);
    @(negedge CLK);
    checkOutput("rise_led0_at4", 32'(LED[0]), 32'd1);
    checkOutput("rise_others_off", 32'(LED[3:1]), 32'd0);
    checkOutput("rise_cnt0", 32'(LOSS_CNT), 32'd0);

    // Single dropout: LED stays dark for 21..30 clocks
    $display("[TB] step 2: single dropout");
    applyStimulus(2'd0);
    waitLed(2'd0, 1'b0, 10, cyc, ok);
    checkOutput("drop_led_fell", 32'(ok), 32'd1);
    waitLed(2'd0, 1'b1, 40, lowLen, ok);
    checkOutput("drop_led_relit", 32'(ok), 32'd1);
    checkOutput("drop_len_21_30", 32'((lowLen >= 21) && (lowLen <= 30)), 32'd1);
    checkOutput("drop_cnt", 32'(LOSS_CNT[1:0]), 32'd1);

    // Clear, then dropouts inside the hold: one hold, one event
    $display("[TB] step 3: dropouts inside hold");
    CNT_CLR = 1'b1;
    @(negedge CLK);
    CNT_CLR = 1'b0;
    checkOutput("clr_cnt", 32'(LOSS_CNT[1:0]), 32'd0);
    applyStimulus(2'd0);
    waitLed(2'd0, 1'b0, 10, cyc, ok);
    checkOutput("multi_led_fell", 32'(ok), 32'd1);
    repeat (5) @(negedge CLK);
    applyStimulus(2'd0);
    repeat (5) @(negedge CLK);
    applyStimulus(2'd0);
    waitLed(2'd0, 1'b1, 40, lowLen, ok);
    checkOutput("multi_led_relit", 32'(ok), 32'd1);
    checkOutput("multi_len_21_30", 32'(((12 + lowLen) >= 21) && ((12 + lowLen) <= 30)), 32'd1);
    checkOutput("multi_cnt", 32'(LOSS_CNT[1:0]), 32'd1);

    // Five separate losses saturate the 2-bit counter
    $display("[TB] step 4: saturation and clear");
    CNT_CLR = 1'b1;
    @(negedge CLK);
    CNT_CLR = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'd0);
      waitLed(2'd0, 1'b0, 10, cyc, ok);
      waitLed(2'd0, 1'b1, 40, cyc, ok);
      checkOutput($sformatf("sat_relit_%0d", i), 32'(ok), 32'd1);
      checkOutput($sformatf("sat_cnt_%0d", i), 32'(LOSS_CNT[1:0]), 32'(expCnt[i]));
    end

    // Clear in the very cycle the loss is taken: the event wins
    SIGNAL_IN[0] = 1'b0;
    @(negedge CLK);
    SIGNAL_IN[0] = 1'b1;
    @(negedge CLK);
    CNT_CLR = 1'b1;
    @(negedge CLK);
    CNT_CLR = 1'b0;
    checkOutput("clr_with_loss", 32'(LOSS_CNT[1:0]), 32'd1);
    waitLed(2'd0, 1'b0, 10, cyc, ok);
    waitLed(2'd0, 1'b1, 40, cyc, ok);
    checkOutput("clr_loss_relit", 32'(ok), 32'd1);

    // Plain clear leaves the LED alone
    CNT_CLR = 1'b1;
    @(negedge CLK);
    CNT_CLR = 1'b0;
    checkOutput("clr_plain_cnt", 32'(LOSS_CNT[1:0]), 32'd0);
    @(negedge CLK);
    checkOutput("clr_plain_led", 32'(LED[0]), 32'd1);

    // Blink on channel 1: toggles every 20 clocks, stops on the next clock
    $display("[TB] step 5: blink");
    SIGNAL_IN[1] = 1'b1;
    waitLed(2'd1, 1'b1, 10, cyc, ok);
    checkOutput("blink_lit", 32'(ok), 32'd1);
    BLINK_EN[1] = 1'b1;
    repeat (2) @(negedge CLK);
    waitToggle(2'd1, 25, cyc, ok);
    checkOutput("blink_align", 32'(ok), 32'd1);
    waitToggle(2'd1, 25, cyc, ok);
    checkOutput("blink_period_a", 32'(cyc), 32'd20);
    waitToggle(2'd1, 25, cyc, ok);
    checkOutput("blink_period_b", 32'(cyc), 32'd20);
    waitLed(2'd1, 1'b0, 25, cyc, ok);
    checkOutput("blink_dark", 32'(ok), 32'd1);
    BLINK_EN[1] = 1'b0;
    @(negedge CLK);
    checkOutput("blink_off_led", 32'(LED[1]), 32'd1);

    // Reset in the middle of a hold on channel 2
    $display("[TB] step 6: reset mid-hold");
    SIGNAL_IN[2] = 1'b1;
    waitLed(2'd2, 1'b1, 10, cyc, ok);
    checkOutput("rst_ch2_lit", 32'(ok), 32'd1);
    applyStimulus(2'd2);
    waitLed(2'd2, 1'b0, 10, cyc, ok);
    checkOutput("rst_ch2_hold", 32'(ok), 32'd1);
    repeat (5) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    checkOutput("rst_led_all", 32'(LED), 32'd0);
    checkOutput("rst_cnt_all", 32'(LOSS_CNT), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("rst_rel_led2_at3", 32'(LED[2]), 32'd0);
    @(negedge CLK);
    checkOutput("rst_rel_led2_at4", 32'(LED[2]), 32'd1);

    $display("[TB] %0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
